// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keypad entry block: scan codes,
// state enumerations and the keypad digit lookup.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] SC_KP0 = 8'h70;
    localparam logic [7:0] SC_KP1 = 8'h69;
    localparam logic [7:0] SC_KP2 = 8'h72;
    localparam logic [7:0] SC_KP3 = 8'h7A;
    localparam logic [7:0] SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73;
    localparam logic [7:0] SC_KP6 = 8'h74;
    localparam logic [7:0] SC_KP7 = 8'h6C;
    localparam logic [7:0] SC_KP8 = 8'h75;
    localparam logic [7:0] SC_KP9 = 8'h7D;

    typedef enum logic [1:0] {FR_IDLE, FR_SHIFT, FR_CHECK} frame_state_t;
    typedef enum logic [1:0] {DEC_NORM, DEC_EXT, DEC_BRK} dec_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_CONV, OUT_HOLD} out_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] digit;
    } digit_lookup_t;

    function automatic digit_lookup_t lookup_digit(input logic [7:0] code);
        digit_lookup_t r;
        r.hit   = 1'b1;
        r.digit = 4'd0;
        case (code)
            SC_KP0:  r.digit = 4'd0;
            SC_KP1:  r.digit = 4'd1;
            SC_KP2:  r.digit = 4'd2;
            SC_KP3:  r.digit = 4'd3;
            SC_KP4:  r.digit = 4'd4;
            SC_KP5:  r.digit = 4'd5;
            SC_KP6:  r.digit = 4'd6;
            SC_KP7:  r.digit = 4'd7;
            SC_KP8:  r.digit = 4'd8;
            SC_KP9:  r.digit = 4'd9;
            default: r.hit   = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: input synchronisers, frame FSM with
// inactivity timeout, odd-parity and stop-bit checking.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    frame_state_t  state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic [TW-1:0] tmo_reg;
    logic [7:0]    byte_reg;
    logic          valid_reg;
    logic          err_reg;

    assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign data_s = data_sync_reg[SYNC_STAGES-1];
    assign fall   = clk_prev_reg & ~clk_s;

    // Synchronisers reset to the idle-high line level so reset release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            clk_prev_reg  <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FR_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 10'd0;
            tmo_reg     <= '0;
            byte_reg    <= 8'd0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                FR_IDLE: begin
                    if (fall && !data_s) begin
                        state_reg   <= FR_SHIFT;
                        bit_cnt_reg <= 4'd0;
                        tmo_reg     <= '0;
                    end
                end
                FR_SHIFT: begin
                    // Bits arrive LSB first; after ten edges [7:0]=data, [8]=parity, [9]=stop.
                    if (fall) begin
                        tmo_reg   <= '0;
                        shift_reg <= {data_s, shift_reg[9:1]};
                        if (bit_cnt_reg == 4'd9) begin
                            state_reg <= FR_CHECK;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_reg <= FR_IDLE;
                        err_reg   <= 1'b1;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                FR_CHECK: begin
                    if ((^shift_reg[8:0]) && shift_reg[9]) begin
                        byte_reg  <= shift_reg[7:0];
                        valid_reg <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                    state_reg <= FR_IDLE;
                end
                default: state_reg <= FR_IDLE;
            endcase
        end
    end

    assign data_byte  = byte_reg;
    assign byte_valid = valid_reg;
    assign frame_err  = err_reg;

endmodule

// File: rtl/ps2_keypad_entry.sv
// Keypad number entry: decodes PS/2 keypad bytes into digit/edit commands,
// buffers digits and converts them to binary on Enter with a valid/ready output.
module ps2_keypad_entry
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_DIGITS     = 4,
    parameter int OUT_W          = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [OUT_W-1:0] value_o,
    output logic             value_valid_o,
    input  logic             value_ready_i,
    output logic [3:0]       digits_o,
    output logic [7:0]       key_code_o,
    output logic             key_valid_o,
    output logic             frame_err_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_byte (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    assign key_code_o  = rx_byte;
    assign key_valid_o = rx_valid;
    assign frame_err_o = rx_err;

    dec_state_t    dec_state_reg;
    dec_state_t    dec_state_next;
    digit_lookup_t lookup;
    logic          ev_digit;
    logic          ev_enter;
    logic          ev_bksp;
    logic          ev_clear;

    assign lookup = lookup_digit(rx_byte);

    // Events are decoded in the same cycle as the byte pulse so Enter latency stays count+1.
    always_comb begin
        dec_state_next = dec_state_reg;
        ev_digit       = 1'b0;
        ev_enter       = 1'b0;
        ev_bksp        = 1'b0;
        ev_clear       = 1'b0;
        if (rx_valid) begin
            case (dec_state_reg)
                DEC_NORM: begin
                    if (rx_byte == SC_BREAK)      dec_state_next = DEC_BRK;
                    else if (rx_byte == SC_EXT)   dec_state_next = DEC_EXT;
                    else if (lookup.hit)          ev_digit       = 1'b1;
                    else if (rx_byte == SC_ENTER) ev_enter       = 1'b1;
                    else if (rx_byte == SC_BKSP)  ev_bksp        = 1'b1;
                    else if (rx_byte == SC_ESC)   ev_clear       = 1'b1;
                end
                DEC_EXT: begin
                    if (rx_byte == SC_BREAK) begin
                        dec_state_next = DEC_BRK;
                    end else begin
                        dec_state_next = DEC_NORM;
                        ev_enter       = (rx_byte == SC_ENTER);
                    end
                end
                DEC_BRK: dec_state_next = DEC_NORM;
                default: dec_state_next = DEC_NORM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_state_reg <= DEC_NORM;
        end else begin
            dec_state_reg <= dec_state_next;
        end
    end

    out_state_t              out_state_reg;
    logic [3:0]              count_reg;
    logic [3:0]              conv_idx_reg;
    logic [OUT_W-1:0]        acc_reg;
    logic [OUT_W-1:0]        acc_next;
    logic [OUT_W-1:0]        value_reg;
    logic                    valid_reg;
    logic                    buf_open;
    logic                    push;
    logic [4*MAX_DIGITS-1:0] slot_bus;
    logic [3:0]              conv_digit;

    // The buffer is frozen while converting so the digits being read cannot move.
    assign buf_open = (out_state_reg != OUT_CONV);
    assign push     = buf_open && ev_digit && (count_reg < 4'(MAX_DIGITS));

    generate
        for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_slot
            logic [3:0] slot_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_reg <= 4'd0;
                end else if (push && (count_reg == 4'(gi))) begin
                    slot_reg <= lookup.digit;
                end
            end
            assign slot_bus[gi*4 +: 4] = slot_reg;
        end
    endgenerate

    always_comb begin
        conv_digit = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (conv_idx_reg == 4'(i)) conv_digit = slot_bus[i*4 +: 4];
        end
    end

    assign acc_next = (acc_reg << 3) + (acc_reg << 1) + OUT_W'(conv_digit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state_reg <= OUT_IDLE;
            count_reg     <= 4'd0;
            conv_idx_reg  <= 4'd0;
            acc_reg       <= '0;
            value_reg     <= '0;
            valid_reg     <= 1'b0;
        end else begin
            if (buf_open) begin
                if (push)                                count_reg <= count_reg + 4'd1;
                else if (ev_bksp && count_reg != 4'd0)   count_reg <= count_reg - 4'd1;
                else if (ev_clear)                       count_reg <= 4'd0;
            end
            case (out_state_reg)
                OUT_IDLE: begin
                    if (ev_enter) begin
                        acc_reg      <= '0;
                        conv_idx_reg <= 4'd0;
                        if (count_reg == 4'd0) begin
                            out_state_reg <= OUT_HOLD;
                            value_reg     <= '0;
                            valid_reg     <= 1'b1;
                        end else begin
                            out_state_reg <= OUT_CONV;
                        end
                    end
                end
                OUT_CONV: begin
                    acc_reg      <= acc_next;
                    conv_idx_reg <= conv_idx_reg + 4'd1;
                    if (conv_idx_reg + 4'd1 == count_reg) begin
                        out_state_reg <= OUT_HOLD;
                        value_reg     <= acc_next;
                        valid_reg     <= 1'b1;
                        count_reg     <= 4'd0;
                    end
                end
                OUT_HOLD: begin
                    if (valid_reg && value_ready_i) begin
                        out_state_reg <= OUT_IDLE;
                        valid_reg     <= 1'b0;
                    end
                end
                default: out_state_reg <= OUT_IDLE;
            endcase
        end
    end

    assign value_o       = value_reg;
    assign value_valid_o = valid_reg;
    assign digits_o      = count_reg;

endmodule

// File: tb/tb_ps2_keypad_entry.sv
// Bench for ps2_keypad_entry: directed scenarios plus random PS/2 frames,
// checked against a queue-based keypad entry model.
module tb_ps2_keypad_entry;

    localparam int TMO  = 200;
    localparam int MAXD = 4;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        value_ready_i = 1'b1;
    logic [31:0] value_o;
    logic        value_valid_o;
    logic [3:0]  digits_o;
    logic [7:0]  key_code_o;
    logic        key_valid_o;
    logic        frame_err_o;

    ps2_keypad_entry #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_DIGITS    (MAXD),
        .OUT_W         (32),
        .SYNC_STAGES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .value_o      (value_o),
        .value_valid_o(value_valid_o),
        .value_ready_i(value_ready_i),
        .digits_o     (digits_o),
        .key_code_o   (key_code_o),
        .key_valid_o  (key_valid_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor
    int          cyc = 0;
    int          kv_cnt = 0;
    int          err_cnt = 0;
    int          rise_cnt = 0;
    int          hs_cnt = 0;
    int          unstable = 0;
    int          last_kv_cyc = 0;
    int          last_rise_cyc = 0;
    int          vlen = 0;
    int          last_vlen = 0;
    logic [7:0]  last_kv_code = 8'd0;
    logic [31:0] last_rise_val = 32'd0;
    logic        vv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid_o) begin
            kv_cnt       <= kv_cnt + 1;
            last_kv_code <= key_code_o;
            last_kv_cyc  <= cyc;
        end
        if (frame_err_o) err_cnt <= err_cnt + 1;
        if (value_valid_o && !vv_prev) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_val <= value_o;
            last_rise_cyc <= cyc;
            vlen          <= 1;
        end else if (value_valid_o) begin
            vlen <= vlen + 1;
            if (value_o !== last_rise_val) unstable <= unstable + 1;
        end else if (vv_prev) begin
            last_vlen <= vlen;
        end
        if (value_valid_o && value_ready_i) hs_cnt <= hs_cnt + 1;
        vv_prev <= value_valid_o;
    end

    // Reference model: a queue of digits, oldest first
    int         m_q[$];
    int         m_mode = 0;          // 0 normal, 1 after E0, 2 after F0
    bit         m_pending = 1'b0;    // a result is presented and not yet accepted
    logic [7:0] m_last_code = 8'd0;
    int         exp_hs = 0;
    logic [7:0] kp_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                  8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    function automatic int digit_of(input logic [7:0] code);
        for (int i = 0; i < 10; i++) if (kp_codes[i] == code) return i;
        return -1;
    endfunction

    task automatic model_enter(output bit enter, output logic [31:0] val, output int cnt);
        enter = 1'b0; val = 32'd0; cnt = 0;
        if (!m_pending) begin
            enter = 1'b1;
            cnt   = m_q.size();
            foreach (m_q[i]) val = val * 10 + 32'(m_q[i]);
            m_q.delete();
            if (value_ready_i) exp_hs++;
            else m_pending = 1'b1;
        end
    endtask

    task automatic model_apply(input logic [7:0] code, output bit enter,
                               output logic [31:0] val, output int cnt);
        int d;
        enter = 1'b0; val = 32'd0; cnt = 0;
        d = digit_of(code);
        if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (code == 8'hF0) m_mode = 2;
            else begin
                m_mode = 0;
                if (code == 8'h5A) model_enter(enter, val, cnt);
            end
        end else begin
            if (code == 8'hF0) m_mode = 2;
            else if (code == 8'hE0) m_mode = 1;
            else if (d >= 0) begin
                if (m_q.size() < MAXD) m_q.push_back(d);
            end else if (code == 8'h5A) model_enter(enter, val, cnt);
            else if (code == 8'h66) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
            end else if (code == 8'h76) m_q.delete();
        end
    endtask

    task automatic set_ready(input bit r);
        value_ready_i = r;
        if (r && m_pending) begin
            m_pending = 1'b0;
            exp_hs++;
        end
    endtask

    task automatic ps2_frame(input logic [7:0] code, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] code);
        int          k0, r0, e0, cnt;
        bit          enter;
        logic [31:0] val;
        k0 = kv_cnt; r0 = rise_cnt; e0 = err_cnt;
        model_apply(code, enter, val, cnt);
        ps2_frame(code, 1'b0, 11);
        repeat (12) @(posedge clk);
        #1;
        m_last_code = code;
        chk_eq("key_valid_count", kv_cnt, k0 + 1);
        chk_eq("key_code", last_kv_code, code);
        chk_eq("frame_err_count", err_cnt, e0);
        chk_eq("digits", digits_o, m_q.size());
        if (enter) begin
            chk_eq("value_rise", rise_cnt, r0 + 1);
            chk_eq("value", last_rise_val, val);
            chk_eq("enter_latency", last_rise_cyc - last_kv_cyc, cnt + 1);
        end else begin
            chk_eq("no_value_rise", rise_cnt, r0);
        end
        chk_eq("handshakes", hs_cnt, exp_hs);
    endtask

    task automatic send_bad(input logic [7:0] code);
        int k0, e0;
        k0 = kv_cnt; e0 = err_cnt;
        ps2_frame(code, 1'b1, 11);
        repeat (12) @(posedge clk);
        #1;
        chk_eq("parity_err_count", err_cnt, e0 + 1);
        chk_eq("parity_no_key", kv_cnt, k0);
        chk_eq("parity_key_code_held", key_code_o, m_last_code);
        chk_eq("parity_digits", digits_o, m_q.size());
    endtask

    initial begin
        int r, e0, k0;
        logic [7:0] code;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("reset_outputs", {value_o, value_valid_o, digits_o, key_code_o, key_valid_o, frame_err_o}, 64'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1234 with ready held high
        set_ready(1'b1);
        send_key(8'h69); send_key(8'h72); send_key(8'h7A); send_key(8'h6B);
        send_key(8'h5A);
        chk_eq("value_1234", last_rise_val, 32'd1234);
        chk_eq("valid_one_cycle", last_vlen, 1);

        // break byte, backspace and extended Enter -> 129
        send_key(8'h69); send_key(8'h72); send_key(8'hF0); send_key(8'h72);
        send_key(8'h7A); send_key(8'h66); send_key(8'h7D);
        send_key(8'hE0); send_key(8'h5A);
        chk_eq("value_129", last_rise_val, 32'd129);

        // saturating buffer
        send_key(8'h69); send_key(8'h72); send_key(8'h7A); send_key(8'h6B);
        send_key(8'h73); send_key(8'h74);
        chk_eq("digits_saturated", digits_o, 4);
        send_key(8'h5A);
        chk_eq("value_saturated", last_rise_val, 32'd1234);

        // bad parity then a timed-out partial frame
        e0 = err_cnt; k0 = kv_cnt;
        send_bad(8'h69);
        ps2_frame(8'h69, 1'b0, 4);
        repeat (TMO + 30) @(posedge clk);
        #1;
        chk_eq("two_frame_errors", err_cnt, e0 + 2);
        chk_eq("no_key_on_errors", kv_cnt, k0);
        chk_eq("digits_after_errors", digits_o, 0);
        send_key(8'h69);
        send_key(8'h76);

        // empty Enter held without ready, second Enter dropped
        set_ready(1'b0);
        send_key(8'h5A);
        repeat (20) @(posedge clk);
        #1;
        chk_eq("held_valid", value_valid_o, 1'b1);
        chk_eq("held_value_zero", value_o, 32'd0);
        send_key(8'h5A);
        set_ready(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("single_handshake", hs_cnt, exp_hs);
        chk_eq("valid_dropped", value_valid_o, 1'b0);

        // reset in the middle of a frame
        send_key(8'h69);
        ps2_frame(8'h70, 1'b0, 5);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("midframe_reset_outputs", {value_o, value_valid_o, digits_o, key_code_o, key_valid_o, frame_err_o}, 64'd0);
        m_q.delete(); m_mode = 0; m_pending = 1'b0; m_last_code = 8'd0;
        e0 = err_cnt;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk_eq("no_err_after_reset", err_cnt, e0);
        send_key(8'h70);
        chk_eq("digit0_after_reset", digits_o, 1);

        // random frames
        for (int n = 0; n < 110; n++) begin
            set_ready($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 50)      code = kp_codes[$urandom_range(0, 9)];
            else if (r < 58) code = 8'h5A;
            else if (r < 64) code = 8'h66;
            else if (r < 68) code = 8'h76;
            else if (r < 74) code = 8'hF0;
            else if (r < 80) code = 8'hE0;
            else             code = 8'($urandom_range(0, 255));
            if (r >= 80 && r < 88) send_bad(code);
            else send_key(code);
        end
        set_ready(1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk_eq("final_handshakes", hs_cnt, exp_hs);
        chk_eq("value_stable_while_valid", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
